// File: rtl/seg_disp_ctrl.sv
// Eight-digit multiplexed seven-segment controller: saturating score/time capture,
// one shared round-robin double-dabble converter, scan with leading-zero blanking.
module seg_disp_ctrl #(
  parameter int W        = 14,
  parameter int PRESCALE = 50000
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic [W-1:0] score_val,
  input  logic         score_ld,
  input  logic [W-1:0] time_val,
  input  logic         time_ld,
  output logic         busy,
  output logic [6:0]   dig,
  output logic [7:0]   an,
  output logic         dp
);

  localparam int BW = 16 + W;
  localparam int CW = $clog2(W + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Valid/ready: a ld strobe is always accepted in its cycle; busy only reports backlog.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   sr;
  logic            cur_score, ptr_score, grant_score, start;
  logic [W-1:0]    score_buf, time_buf;
  logic            score_pend, time_pend;
  logic [15:0]     score_bcd, time_bcd;
  logic [PW-1:0]   presc;
  logic [2:0]      idx;
  logic [15:0]     field;
  logic [1:0]      pos;
  logic [3:0]      nib;
  logic            blank;
  logic [6:0]      seg_nxt;

  function automatic logic [W-1:0] sat(input logic [W-1:0] v);
    if (32'(v) > 32'd9999) return W'(32'd9999);
    return v;
  endfunction

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] s);
    logic [BW-1:0] t;
    t = s;
    for (int i = 0; i < 4; i++)
      if (t[W+4*i +: 4] >= 4'd5) t[W+4*i +: 4] = t[W+4*i +: 4] + 4'd3;
    return {t[BW-2:0], 1'b0};
  endfunction

  always_comb begin
    grant_score = score_pend & (~time_pend | ptr_score);
    start       = (state == IDLE) & (score_pend | time_pend);
    state_nxt   = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      cur_score  <= 1'b0;
      ptr_score  <= 1'b1;
      score_buf  <= '0;
      time_buf   <= '0;
      score_pend <= 1'b0;
      time_pend  <= 1'b0;
      score_bcd  <= '0;
      time_bcd   <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE) | score_pend | time_pend;
      case (state)
        IDLE: if (start) begin
          sr        <= {16'b0, grant_score ? score_buf : time_buf};
          cur_score <= grant_score;
          ptr_score <= ~grant_score;
          cnt       <= '0;
          if (grant_score) score_pend <= 1'b0;
          else             time_pend  <= 1'b0;
        end
        SHIFT: begin
          sr  <= dd_step(sr);
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (cur_score) score_bcd <= sr[BW-1:W];
          else           time_bcd  <= sr[BW-1:W];
        end
        default: ;
      endcase
      // Strobes come last so a re-strobe wins over the grant clearing its flag.
      if (score_ld) begin
        score_buf  <= sat(score_val);
        score_pend <= 1'b1;
      end
      if (time_ld) begin
        time_buf  <= sat(time_val);
        time_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    field = idx[2] ? time_bcd : score_bcd;
    pos   = idx[1:0];
    nib   = field[4*pos +: 4];
    case (pos)
      2'd1:    blank = (field[15:4] == 12'd0);
      2'd2:    blank = (field[15:8] == 8'd0);
      2'd3:    blank = (field[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    case (nib)
      4'd0:    seg_nxt = 7'b0000001;
      4'd1:    seg_nxt = 7'b1001111;
      4'd2:    seg_nxt = 7'b0010010;
      4'd3:    seg_nxt = 7'b0000110;
      4'd4:    seg_nxt = 7'b1001100;
      4'd5:    seg_nxt = 7'b0100100;
      4'd6:    seg_nxt = 7'b0100000;
      4'd7:    seg_nxt = 7'b0001111;
      4'd8:    seg_nxt = 7'b0000000;
      4'd9:    seg_nxt = 7'b0001100;
      default: seg_nxt = 7'b1111111;
    endcase
    if (blank) seg_nxt = 7'b1111111;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= 8'hFF;
      dig   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      if (presc == PW'(PRESCALE - 1)) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      an  <= ~(8'd1 << idx);
      dig <= seg_nxt;
      dp  <= ~(idx == 3'd4);
    end
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Randomised bench for seg_disp_ctrl: a transaction-level model of capture, arbitration,
// conversion timing and the decimal scan predicts an/dig/dp/busy on every cycle.
module tb_seg_disp_ctrl;
  localparam int W = 14;
  localparam int P = 4;

  logic         ck, rst_n;
  logic [W-1:0] score_val, time_val;
  logic         score_ld, time_ld;
  logic         busy, dp;
  logic [6:0]   dig;
  logic [7:0]   an;

  int n_chk, n_fail;

  // model state (decimal integers, not BCD)
  int mk, f_sc, f_tm, sh_sc, sh_tm, b_sc, b_tm, cval, rem;
  bit ps, pt, act, ptr_sc, cur_sc, busy_m, pre;

  seg_disp_ctrl #(.W(W), .PRESCALE(P)) dut (
    .ck(ck), .rst_n(rst_n), .score_val(score_val), .score_ld(score_ld),
    .time_val(time_val), .time_ld(time_ld), .busy(busy), .dig(dig), .an(an), .dp(dp)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0001100;  default: return 7'b1111111;
    endcase
  endfunction

  // Expected {an, dig, dp} after the mk-th edge since reset release.
  function automatic logic [15:0] exp_out();
    int slot, j, v, p, d;
    logic [7:0] a;
    logic [6:0] g;
    if (mk == 0) return {8'hFF, 7'h7F, 1'b1};
    slot = ((mk - 1) / P) % 8;
    v = (slot < 4) ? sh_sc : sh_tm;
    j = slot % 4;
    p = 1;
    for (int i = 0; i < j; i++) p = p * 10;
    d = (v / p) % 10;
    a = ~(8'd1 << slot);
    g = (j != 0 && v < p) ? 7'h7F : seg(d);
    return {a, g, (slot != 4)};
  endfunction

  task automatic model_reset();
    mk = 0; f_sc = 0; f_tm = 0; sh_sc = 0; sh_tm = 0; b_sc = 0; b_tm = 0;
    cval = 0; rem = 0; ps = 0; pt = 0; act = 0; ptr_sc = 1; cur_sc = 0; busy_m = 0;
  endtask

  // One clock: advance the model at the edge, then return at the following negedge.
  task automatic tick();
    @(posedge ck);
    if (!rst_n) model_reset();
    else begin
      pre = ps | pt;
      sh_sc = f_sc;
      sh_tm = f_tm;
      if (act) begin
        rem = rem - 1;
        if (rem == 0) begin
          if (cur_sc) f_sc = cval; else f_tm = cval;
          act = 0;
        end
      end else if (ps | pt) begin
        cur_sc = ps && (!pt || ptr_sc);
        ptr_sc = !cur_sc;
        cval = cur_sc ? b_sc : b_tm;
        if (cur_sc) ps = 0; else pt = 0;
        act = 1;
        rem = 15;   // grant edge to field-write edge
      end
      if (score_ld) begin b_sc = sat(int'(score_val)); ps = 1; end
      if (time_ld)  begin b_tm = sat(int'(time_val));  pt = 1; end
      busy_m = act | pre;
      mk = mk + 1;
    end
    @(negedge ck);
    score_ld = 1'b0;
    time_ld  = 1'b0;
  endtask

  task automatic ld_score(input int v);
    score_val = W'(v);
    score_ld  = 1'b1;
  endtask

  task automatic ld_time(input int v);
    time_val = W'(v);
    time_ld  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; score_ld = 0; time_ld = 0; score_val = '0; time_val = '0;
    model_reset();
    repeat (3) begin
      tick();
      n_chk++;
      if ({an, dig, dp, busy} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold got an=%h dig=%b dp=%b busy=%b exp an=ff dig=1111111 dp=1 busy=0", an, dig, dp, busy);
      end
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({an, dig, dp, busy} !== {8'hFE, 7'b0000001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_edge got an=%h dig=%b dp=%b busy=%b exp an=fe dig=0000001 dp=1 busy=0", an, dig, dp, busy);
    end
  endtask

  task automatic test_basic();
    ld_score(1234);
    repeat (16 + 8 * P + 4) begin
      tick();
      n_chk++;
      if ({an, dig, dp, busy} !== {exp_out(), busy_m}) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got %h/%b/%b/%b exp %h/%b", mk, an, dig, dp, busy, exp_out(), busy_m);
      end
    end
  endtask

  task automatic test_blank_sat();
    int vals[3] = '{7, 12000, 0};
    for (int t = 0; t < 3; t++) begin
      if (t == 2) ld_time(vals[t]); else ld_score(vals[t]);
      repeat (16 + 8 * P) begin
        tick();
        n_chk++;
        if ({an, dig, dp, busy} !== {exp_out(), busy_m}) begin
          n_fail++;
          $display("FAIL blank_sat v=%0d cyc=%0d got %h/%b/%b/%b exp %h/%b", vals[t], mk, an, dig, dp, busy, exp_out(), busy_m);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    for (int t = 0; t < 2; t++) begin
      ld_score(t == 0 ? 5 : int'($urandom_range(0, 16383)));
      ld_time(t == 0 ? 60 : int'($urandom_range(0, 16383)));
      repeat (32 + 8 * P) begin
        tick();
        n_chk++;
        if ({an, dig, dp, busy} !== {exp_out(), busy_m}) begin
          n_fail++;
          $display("FAIL arbitration pair=%0d cyc=%0d got %h/%b/%b/%b exp %h/%b", t, mk, an, dig, dp, busy, exp_out(), busy_m);
        end
      end
    end
  endtask

  task automatic test_restrobe();
    ld_time(30);
    for (int c = 0; c < 32 + 8 * P; c++) begin
      if (c == 5) ld_time(45);
      tick();
      n_chk++;
      if ({an, dig, dp, busy} !== {exp_out(), busy_m}) begin
        n_fail++;
        $display("FAIL restrobe cyc=%0d got %h/%b/%b/%b exp %h/%b", mk, an, dig, dp, busy, exp_out(), busy_m);
      end
    end
  endtask

  task automatic test_random();
    repeat (30) begin
      case ($urandom_range(0, 3))
        0: ld_score(int'($urandom_range(0, 16383)));
        1: ld_time(int'($urandom_range(0, 16383)));
        2: begin ld_score(int'($urandom_range(0, 9999))); ld_time(int'($urandom_range(0, 9999))); end
        default: ;
      endcase
      repeat ($urandom_range(1, 40)) begin
        tick();
        n_chk++;
        if ({an, dig, dp, busy} !== {exp_out(), busy_m}) begin
          n_fail++;
          $display("FAIL random cyc=%0d got %h/%b/%b/%b exp %h/%b", mk, an, dig, dp, busy, exp_out(), busy_m);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ld_score(4321);
    ld_time(8765);
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    n_chk++;
    if ({an, dig, dp, busy} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_async got an=%h dig=%b dp=%b busy=%b exp an=ff dig=1111111 dp=1 busy=0", an, dig, dp, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40 + 8 * P) begin
      tick();
      n_chk++;
      if ({an, dig, dp, busy} !== {exp_out(), busy_m}) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc=%0d got %h/%b/%b/%b exp %h/%b", mk, an, dig, dp, busy, exp_out(), busy_m);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_blank_sat();
    test_arbitration();
    test_restrobe();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Display controller for the board's 8-digit multiplexed seven-segment display. It accepts binary score and time values from the game logic and converts each to 4 BCD digits on one shared sequential double-dabble converter, arbitrated round-robin between the two requesters. It then scans all 8 digits with leading-zero blanking. It replaces direct digit-driving logic in the top level and is the only block that drives `dig`, `an` and `dp`.

## Interface
- `W`, 14: binary width of each input value.
- `PRESCALE`, 50000: `ck` cycles per digit slot. Must be ≥ 2.

- `ck` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `score_val` in W: score value in binary.
- `score_ld` in 1: one-cycle strobe; captures `score_val`.
- `time_val` in W: time value in binary.
- `time_ld` in 1: one-cycle strobe; captures `time_val`.
- `busy` out 1: high while either request is pending or a conversion is running.
- `dig` out 7: active-low cathodes, bit order {a,b,c,d,e,f,g}. Encodings 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100. Blank is 1111111.
- `an` out 8: active-low one-hot anode select.
- `dp` out 1: active-low decimal point.

## Operation
- **Request capture.** At each `ck` edge, `score_ld`/`time_ld` copies the value into that requester's buffer and sets its pending flag. Values above 9999 saturate to 9999 at capture. A new strobe overwrites the buffer even while that requester is pending or being converted.
- **Converter FSM.** States: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when any pending flag is set. The granted buffer loads into the shift register, the granted pending flag clears, and the bit counter goes to 0.
  - SHIFT: W double-dabble steps, one per cycle (add 3 to every BCD nibble ≥ 5, then shift left by 1). After step W the FSM goes to DONE.
  - DONE: write 4 BCD digits to the granted field register in one edge, then return to IDLE.
- **Arbitration.** If only one request is pending, it is granted. If both are pending, grant the requester not served last. After reset the pointer favours score.
- **Re-strobe during conversion.** A strobe for the requester currently converting sets its pending flag again. The in-flight result is still written, then the new value is converted.
- **Busy.** `busy` = (state ≠ IDLE) | score_pending | time_pending. It is registered.
- **Display mapping.**
  - Score field: digit 0 = ones … digit 3 = thousands, on `an[3:0]`.
  - Time field: ones to thousands on `an[7:4]`.
- **Scan.** The prescaler counts 0..PRESCALE-1. On wrap, the digit index (0..7) increments and wraps from 7 to 0.
- **Leading-zero blanking.** Within each field, a digit is blank if it and all higher digits of that field are 0. Digit 0 and digit 4 are never blanked.
- **Decimal point.** `dp` is low only while `an` = 11101111, marking the field separator. Otherwise it is 1.

## Timing
- **Reset state.**
  - Outputs: `dig`=1111111, `an`=11111111, `dp`=1, `busy`=0.
  - Internal: field registers = 0; buffers, pending flags, prescaler and index = 0; FSM = IDLE; arbitration pointer favours score.
- **Reset mid-operation.** Any in-flight conversion or pending request is discarded. No field is written.
- **Output registering.** `dig`/`an`/`dp` are registered from the current index and field registers, so they lag by 1 cycle. The first edge after reset release gives `an`=11111110 and `dig`=0000001.
- **Conversion latency.**
  - Strobe sampled at edge E0, converter idle.
  - Grant at E1; shifts at E2..E(W+1); field written at E(W+2). With W=14 that is 16 cycles.
  - `busy` rises at E1 and falls at E(W+2) if nothing else is pending.
- **Back-to-back requests.** The second conversion is granted the edge after DONE. Worst case from strobe to field update is 2W+4 cycles.
- **Atomic update.** A field changes on one edge only. The scan never shows a mix of old and new digits within a field.
- **Digit dwell.** Each `an` value is held exactly PRESCALE cycles. A full refresh takes 8·PRESCALE cycles.

## Test plan
- **Reset.** Assert `rst_n` low mid-scan and mid-conversion → outputs go immediately to 1111111/FF/1, `busy`=0. After release the first edge gives `an`=FE, `dig`=0000001. A pre-reset request is never displayed.
- **Basic conversion.** `score_ld` with 1234, W=14, PRESCALE=4 → `busy` high E1..E15, field updated at E16. The scan shows 4/3/2/1 on `an` FE/FD/FB/F7 with 4 cycles each.
- **Blanking and saturation.**
  - Score 7 → `an` FD/FB/F7 show 1111111 and FE shows 0001111.
  - Score 12000 → 9999 on all four score digits.
  - Time 0 → only `an`=EF lit, showing 0000001 with `dp`=0.
- **Arbitration.** Same-cycle `score_ld`=5 and `time_ld`=60 → score written at E16, time at E32. Next simultaneous pair → score served first, since time was served last.
- **Re-strobe.** `time_ld`=30 at E0, then `time_ld`=45 at E5 → time field shows 30 at E16, 45 at E32, and `busy` stays high throughout.
